// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - MIPS execute stage: forwarding, ALU, destination select, EX/MEM register
module ex_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [4:0]       rt_addr,
    input  logic [4:0]       rd_addr,
    input  logic             reg_dst,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             mem_to_reg_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] store_data,
    output logic [4:0]       write_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic             r_valid;
    logic [WIDTH-1:0] r_alu_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_store_data;
    logic [4:0]       r_write_reg;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;

    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_fb;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_result;
    logic [4:0]       w_dest;

    // Forward path 10 reads the EX/MEM register itself, giving back-to-back dependent ops.
    always_comb begin
        w_opa = rs_data;
        case (fwd_a)
            2'b01:   w_opa = wb_data;
            2'b10:   w_opa = r_alu_result;
            default: w_opa = rs_data;
        endcase
        w_fb = rt_data;
        case (fwd_b)
            2'b01:   w_fb = wb_data;
            2'b10:   w_fb = r_alu_result;
            default: w_fb = rt_data;
        endcase
    end

    assign w_opb  = alu_src ? imm : w_fb;
    assign w_dest = reg_dst ? rd_addr : rt_addr;

    always_comb begin
        w_result = '0;
        case (operation)
            OP_ADD:  w_result = w_opa + w_opb;
            OP_SUB:  w_result = w_opa - w_opb;
            OP_AND:  w_result = w_opa & w_opb;
            OP_OR:   w_result = w_opa | w_opb;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
            OP_NOR:  w_result = ~(w_opa | w_opb);
            default: w_result = '0;
        endcase
    end

    // Bubbles clear everything but keep zero=1 so it agrees with the cleared result.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b1;
            r_store_data <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (stall) begin
            r_valid      <= r_valid;
            r_alu_result <= r_alu_result;
            r_zero       <= r_zero;
            r_store_data <= r_store_data;
            r_write_reg  <= r_write_reg;
            r_reg_write  <= r_reg_write;
            r_mem_read   <= r_mem_read;
            r_mem_write  <= r_mem_write;
            r_mem_to_reg <= r_mem_to_reg;
        end else if (!in_valid) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_zero       <= 1'b1;
            r_store_data <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_valid      <= 1'b1;
            r_alu_result <= w_result;
            r_zero       <= (w_result == '0);
            r_store_data <= w_fb;
            r_write_reg  <= w_dest;
            r_reg_write  <= reg_write_in;
            r_mem_read   <= mem_read_in;
            r_mem_write  <= mem_write_in;
            r_mem_to_reg <= mem_to_reg_in;
        end
    end

    assign out_valid  = r_valid;
    assign alu_result = r_alu_result;
    assign zero       = r_zero;
    assign store_data = r_store_data;
    assign write_reg  = r_write_reg;
    assign reg_write  = r_reg_write;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_to_reg = r_mem_to_reg;

endmodule
